// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator: one shared period counter, per-channel double-buffered
// pulse width (target -> active) committed at period boundaries with optional slew limit.
module pwm_multicanal #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned PERIODO  = 50000,
    parameter int unsigned LARG_INI = 0,
    parameter int unsigned PASSO    = 0,
    localparam int unsigned CW      = $clog2(PERIODO + 1),
    localparam int unsigned AW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] habilita,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_canal,
    input  logic [CW-1:0]  wr_largura,
    output logic           wr_ack,
    output logic           wr_erro,
    output logic [NCH-1:0] pwm,
    output logic [NCH-1:0] db_pwm,
    output logic           fim_periodo,
    output logic           estavel
);

    localparam logic [CW-1:0] ULTIMO = CW'(PERIODO - 1);
    localparam logic [CW-1:0] MAXL   = CW'(PERIODO);
    localparam logic [CW-1:0] INI    = CW'(LARG_INI);

    logic [CW-1:0]  contagem;
    logic [CW-1:0]  alvo       [NCH];
    logic [CW-1:0]  ativo      [NCH];
    logic [CW-1:0]  ativo_prox [NCH];
    logic [NCH-1:0] pwm_prox;
    logic           fim;
    logic           canal_ok;
    logic [CW-1:0]  largura_sat;

    // Largest step allowed toward the target; dif is already nonzero and bounded by PERIODO.
    function automatic logic [CW-1:0] passo_lim(input logic [CW-1:0] dif);
        return (32'(dif) > PASSO) ? CW'(PASSO) : dif;
    endfunction

    assign fim         = (contagem == ULTIMO);
    assign canal_ok    = (32'(wr_canal) < NCH);
    assign largura_sat = (wr_largura > MAXL) ? MAXL : wr_largura;

    // Next active width per channel, applied only at the period boundary.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ativo_prox[i] = ativo[i];
            if (PASSO == 0)
                ativo_prox[i] = alvo[i];
            else if (alvo[i] > ativo[i])
                ativo_prox[i] = ativo[i] + passo_lim(alvo[i] - ativo[i]);
            else if (alvo[i] < ativo[i])
                ativo_prox[i] = ativo[i] - passo_lim(ativo[i] - alvo[i]);
        end
    end

    always_comb begin
        pwm_prox = '0;
        estavel  = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            pwm_prox[i] = habilita[i] & (contagem < ativo[i]);
            if (ativo[i] != alvo[i])
                estavel = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem    <= '0;
            pwm         <= '0;
            db_pwm      <= '0;
            wr_ack      <= 1'b0;
            wr_erro     <= 1'b0;
            fim_periodo <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                alvo[i]  <= INI;
                ativo[i] <= INI;
            end
        end else begin
            contagem    <= fim ? '0 : contagem + CW'(1);
            fim_periodo <= fim;
            wr_ack      <= wr_en & canal_ok;
            wr_erro     <= wr_en & ~canal_ok;
            pwm         <= pwm_prox;
            db_pwm      <= pwm_prox;
            // Commit reads the pre-edge target, so a write on the boundary lands one period later.
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wr_en && canal_ok && (wr_canal == AW'(i)))
                    alvo[i] <= largura_sat;
                if (fim)
                    ativo[i] <= ativo_prox[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Bench for pwm_multicanal: two instances (jump and slew-limited) sharing stimulus,
// checked every cycle against a per-period width model plus directed width counts.
module tb_pwm_multicanal;

    localparam int unsigned NCH     = 3;
    localparam int unsigned P       = 10;
    localparam int unsigned PASSO_B = 2;
    localparam int unsigned CW      = 4;
    localparam int unsigned AW      = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] habilita;
    logic           wr_en;
    logic [AW-1:0]  wr_canal;
    logic [CW-1:0]  wr_largura;

    logic           ack_a, erro_a, fim_a, est_a, ack_b, erro_b, fim_b, est_b;
    logic [NCH-1:0] pwm_a, db_a, pwm_b, db_b;

    always #5 clock = ~clock;

    pwm_multicanal #(.NCH(NCH), .PERIODO(P), .LARG_INI(0), .PASSO(0)) dut_a (
        .clock(clock), .reset(reset), .habilita(habilita), .wr_en(wr_en),
        .wr_canal(wr_canal), .wr_largura(wr_largura), .wr_ack(ack_a), .wr_erro(erro_a),
        .pwm(pwm_a), .db_pwm(db_a), .fim_periodo(fim_a), .estavel(est_a));

    pwm_multicanal #(.NCH(NCH), .PERIODO(P), .LARG_INI(0), .PASSO(PASSO_B)) dut_b (
        .clock(clock), .reset(reset), .habilita(habilita), .wr_en(wr_en),
        .wr_canal(wr_canal), .wr_largura(wr_largura), .wr_ack(ack_b), .wr_erro(erro_b),
        .pwm(pwm_b), .db_pwm(db_b), .fim_periodo(fim_b), .estavel(est_b));

    int n_cmp = 0;
    int n_err = 0;

    // Reference: position in period plus target/active width per channel.
    int             cnt;
    int             tgt   [NCH];
    int             act_a [NCH];
    int             act_b [NCH];
    logic [NCH-1:0] e_pwm_a, e_pwm_b;
    logic           e_ack, e_erro, e_fim, e_est_a, e_est_b;

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    function automatic int slew(input int a, input int t, input int passo);
        if (passo == 0) return t;
        if (t > a) return a + imin(passo, t - a);
        if (t < a) return a - imin(passo, a - t);
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) begin
            cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                tgt[i] = 0; act_a[i] = 0; act_b[i] = 0;
            end
            e_pwm_a = '0; e_pwm_b = '0; e_ack = 0; e_erro = 0; e_fim = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                e_pwm_a[i] = habilita[i] && (cnt < act_a[i]);
                e_pwm_b[i] = habilita[i] && (cnt < act_b[i]);
            end
            e_fim = (cnt == P - 1);
            if (e_fim)
                for (int i = 0; i < NCH; i++) begin
                    act_a[i] = slew(act_a[i], tgt[i], 0);
                    act_b[i] = slew(act_b[i], tgt[i], PASSO_B);
                end
            e_ack  = wr_en && (int'(wr_canal) < NCH);
            e_erro = wr_en && (int'(wr_canal) >= NCH);
            if (e_ack) tgt[wr_canal] = imin(int'(wr_largura), P);
            cnt = (cnt + 1) % P;
        end
        e_est_a = 1; e_est_b = 1;
        for (int i = 0; i < NCH; i++) begin
            if (act_a[i] != tgt[i]) e_est_a = 0;
            if (act_b[i] != tgt[i]) e_est_b = 0;
        end
        #1;
        check("pwm_a", 32'(pwm_a), 32'(e_pwm_a));
        check("db_pwm_a", 32'(db_a), 32'(e_pwm_a));
        check("pwm_b", 32'(pwm_b), 32'(e_pwm_b));
        check("db_pwm_b", 32'(db_b), 32'(e_pwm_b));
        check("wr_ack", 32'({ack_a, ack_b}), 32'({e_ack, e_ack}));
        check("wr_erro", 32'({erro_a, erro_b}), 32'({e_erro, e_erro}));
        check("fim_periodo", 32'({fim_a, fim_b}), 32'({e_fim, e_fim}));
        check("estavel", 32'({est_a, est_b}), 32'({e_est_a, e_est_b}));
    endtask

    task automatic wr(input int c, input int w);
        wr_en = 1; wr_canal = AW'(c); wr_largura = CW'(w);
        step();
        wr_en = 0;
    endtask

    task automatic to_boundary();
        for (int k = 0; k <= P && cnt != 0; k++) step();
    endtask

    // High cycles of a0/a1/b0 over one full period starting at the boundary.
    task automatic measure(output int a0, output int a1, output int b0);
        a0 = 0; a1 = 0; b0 = 0;
        repeat (P) begin
            step();
            a0 += int'(pwm_a[0]); a1 += int'(pwm_a[1]); b0 += int'(pwm_b[0]);
        end
    endtask

    int a0, a1, b0, k;
    int exp_b_up [5];
    int exp_b_dn [3];

    initial begin
        exp_b_up = '{2, 4, 6, 7, 7};
        exp_b_dn = '{5, 3, 1};
        reset = 1; habilita = '1; wr_en = 0; wr_canal = '0; wr_largura = '0;
        repeat (3) step();
        reset = 0;
        step();

        // Slew ramp up and down on channel 0
        wr(0, 7);
        to_boundary();
        for (int i = 0; i < 5; i++) begin
            measure(a0, a1, b0);
            check("ramp_up_a0", 32'(a0), 32'd7);
            check("ramp_up_a1", 32'(a1), 32'd0);
            check("ramp_up_b0", 32'(b0), 32'(exp_b_up[i]));
        end
        wr(0, 1);
        to_boundary();
        for (int i = 0; i < 3; i++) begin
            measure(a0, a1, b0);
            check("ramp_dn_a0", 32'(a0), 32'd1);
            check("ramp_dn_b0", 32'(b0), 32'(exp_b_dn[i]));
        end

        // Basic width with stability flag
        wr(0, 3);
        check("estavel_pending", 32'(est_a), 32'd0);
        to_boundary();
        measure(a0, a1, b0);
        check("width3_a0", 32'(a0), 32'd3);
        check("width3_a1", 32'(a1), 32'd0);
        check("width3_b0", 32'(b0), 32'd3);
        check("estavel_after", 32'(est_a), 32'd1);

        // Clamp and zero width
        wr(1, 15);
        to_boundary();
        measure(a0, a1, b0);
        check("clamp_a1", 32'(a1), 32'd10);
        wr(1, 0);
        to_boundary();
        measure(a0, a1, b0);
        check("zero_a1", 32'(a1), 32'd0);

        // Invalid channel
        wr(3, 5);
        check("bad_erro", 32'(erro_a), 32'd1);
        check("bad_ack", 32'(ack_a), 32'd0);
        to_boundary();
        measure(a0, a1, b0);
        check("bad_keep_a0", 32'(a0), 32'd3);
        check("bad_keep_a1", 32'(a1), 32'd0);

        // Write on the boundary cycle commits one period late
        for (int i = 0; i < 2 * P && cnt != P - 1; i++) step();
        wr(0, 4);
        measure(a0, a1, b0);
        check("late_old_a0", 32'(a0), 32'd3);
        measure(a0, a1, b0);
        check("late_new_a0", 32'(a0), 32'd4);
        check("late_new_b0", 32'(b0), 32'd4);

        // Enable drop mid-pulse, then reset mid-period
        step(); step();
        habilita[0] = 0;
        step();
        check("hab_off", 32'(pwm_a[0]), 32'd0);
        habilita = '1;
        repeat (3) step();
        reset = 1;
        step();
        check("rst_pwm", 32'({pwm_a, db_a}), 32'd0);
        check("rst_fim", 32'(fim_a), 32'd0);
        reset = 0;
        k = 0;
        for (int i = 1; i <= 3 * P; i++) begin
            step();
            if (fim_a === 1'b1) begin k = i; break; end
        end
        check("first_fim", 32'(k), 32'(P));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_canal   = AW'($urandom_range(0, 3));
            wr_largura = CW'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) habilita = NCH'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
